// File: rtl/key_pulse_gen_if.sv
// Board pin bundle between the raw KEY/SW pins and the game logic.
// master drives the raw pins and LOCK; slave is the conditioner.
interface key_pulse_gen_if;
  logic [4:0] KEY;
  logic [6:0] SW;
  logic       LOCK;
  logic       READY;
  logic       QUE;
  logic       WRONG;
  logic       DEC;
  logic       CLR;
  logic [2:0] SEL;
  logic [1:0] JUDG;
  logic [1:0] HP;
  logic [4:0] KEY_HELD;

  modport master (
    output KEY, SW, LOCK,
    input  READY, QUE, WRONG, DEC, CLR,
    input  SEL, JUDG, HP, KEY_HELD
  );

  modport slave (
    input  KEY, SW, LOCK,
    output READY, QUE, WRONG, DEC, CLR,
    output SEL, JUDG, HP, KEY_HELD
  );
endinterface

// File: rtl/key_pulse_gen.sv
// Pushbutton/switch conditioner: sync, debounce, one-cycle key pulses.
// Ports: CLK, RST (async low), pins (KEY/SW/LOCK in; pulses/levels out).
module key_pulse_gen #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic            CLK,
  input  logic            RST,
  key_pulse_gen_if.slave  pins
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    HELD      = 2'b10,
    RELEASING = 2'b11
  } key_st_e;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  // keys idle high, switches idle low
  localparam logic [11:0] SYNC_RST = 12'h01F;

  logic [11:0] sync1;
  logic [11:0] sync2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= {pins.SW, pins.KEY};
      sync2 <= sync1;
    end
  end

  // Key state bit 1 is the accepted level,
  // bit 0 marks a pending (counting) change.
  key_st_e          st_q   [5];
  key_st_e          st_d   [5];
  logic [CNT_W-1:0] kcnt_q [5];
  logic [CNT_W-1:0] kcnt_d [5];
  logic [4:0]       prs;
  logic [4:0]       same;
  logic [4:0]       done;
  logic [4:0]       acc_d;
  logic [4:0]       hit_q;
  logic [4:0]       pulse_q;
  logic [4:0]       held;

  assign prs = ~sync2[4:0];

  always_comb begin
    acc_d = '0;
    same  = '0;
    done  = '0;
    for (int i = 0; i < 5; i++) begin
      st_d[i]   = st_q[i];
      kcnt_d[i] = '0;
      same[i]   = prs[i] == st_q[i][1];
      done[i]   = !same[i] && kcnt_q[i] == LAST;
      unique case (1'b1)
        same[i]: begin
          st_d[i] = st_q[i][1] ? HELD : IDLE;
        end
        done[i]: begin
          st_d[i]  = prs[i] ? HELD : IDLE;
          acc_d[i] = prs[i];
        end
        default: begin
          kcnt_d[i] = kcnt_q[i] + ONE;
          st_d[i]   = st_q[i][1] ? RELEASING
                                 : ARMING;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 5; i++) begin
        st_q[i]   <= IDLE;
        kcnt_q[i] <= '0;
      end
      hit_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        st_q[i]   <= st_d[i];
        kcnt_q[i] <= kcnt_d[i];
      end
      // hit_q marks the first HELD cycle;
      // LOCK is judged in that cycle.
      hit_q   <= acc_d;
      pulse_q <= hit_q & ~{5{pins.LOCK}};
    end
  end

  always_comb begin
    held = '0;
    for (int i = 0; i < 5; i++) begin
      held[i] = st_q[i] inside {HELD, RELEASING};
    end
  end

  logic [6:0]       sw_q;
  logic [CNT_W-1:0] scnt_q [7];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sw_q <= '0;
      for (int j = 0; j < 7; j++) begin
        scnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 7; j++) begin
        if (sync2[5+j] == sw_q[j]) begin
          scnt_q[j] <= '0;
        end else if (scnt_q[j] == LAST) begin
          sw_q[j]   <= sync2[5+j];
          scnt_q[j] <= '0;
        end else begin
          scnt_q[j] <= scnt_q[j] + ONE;
        end
      end
    end
  end

  assign pins.READY    = pulse_q[0];
  assign pins.QUE      = pulse_q[1];
  assign pins.WRONG    = pulse_q[2];
  assign pins.DEC      = pulse_q[3];
  assign pins.CLR      = pulse_q[4];
  assign pins.KEY_HELD = held;
  assign pins.SEL      = sw_q[2:0];
  assign pins.JUDG     = sw_q[4:3];
  assign pins.HP       = sw_q[6:5];

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Front-end conditioner for the board's pushbuttons and slide switches in the factorization quiz.
- Synchronises and debounces the raw active-low KEY and SW pins.
- Drives CONTROL and INPUT with what they consume: one-cycle command pulses (READY, QUE, WRONG, DEC, CLR) and stable levels (SEL, JUDG, HP).
- Sits between the board pins and the game top level, replacing direct pin wiring.

## Interface
Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- CNT_W, 19: debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- KEY  in  5  raw pushbuttons, active-low. Bit 0 READY, bit 1 QUE, bit 2 WRONG, bit 3 DEC, bit 4 CLR.
- SW  in  7  raw slide switches, active-high. Bits [2:0] SEL, [4:3] JUDG, [6:5] HP.
- LOCK  in  1  synchronous; when 1, suppresses command pulses only. Debounce logic keeps running.
- READY, QUE, WRONG, DEC, CLR  out  1 each  one-cycle pulse per accepted press.
- SEL  out  3  debounced SW[2:0].
- JUDG  out  2  debounced SW[4:3].
- HP  out  2  debounced SW[6:5].
- KEY_HELD  out  5  1 while the corresponding key is in the accepted-pressed state.

## Operation
- Every KEY and SW bit passes through a 2-flop synchroniser.
  - Reset value: 1 for KEY bits (released), 0 for SW bits.
- Each bit has an independent debouncer: one stable register, one CNT_W counter.
  - Synchronised value equals stable: counter cleared to 0.
  - Otherwise: counter increments.
  - Counter at DEB_CYCLES-1 with value still differing: stable takes the synchronised value and the counter clears, in the same cycle.
  - Any return to the stable value before that point clears the counter. A glitch shorter than DEB_CYCLES cycles therefore never changes stable.
- Per-key state machine, derived from stable and counter:
  - IDLE: released, counter 0.
  - ARMING: released, counter > 0. Goes to HELD when the press is accepted, back to IDLE on a bounce.
  - HELD: pressed, counter 0.
  - RELEASING: pressed, counter > 0. Goes to IDLE when the release is accepted, back to HELD on a bounce.
- Command pulse output is registered.
  - It is 1 for exactly the cycle after the ARMING->HELD transition, provided LOCK was 0 in the transition cycle.
  - No pulse on release. No repeat while held.
- KEY_HELD[i] = 1 in HELD and RELEASING.
- Keys are fully independent. Simultaneous accepted presses produce simultaneous pulses; there is no priority.
- SEL, JUDG, HP are the switch stable registers, updated bitwise with no pulse. A multi-bit switch change may appear over several cycles if the bits settle at different times.
- LOCK asserted while a key is HELD: no retroactive pulse on deassertion.
- Reset values of all outputs: pulses 0, KEY_HELD 0, SEL 0, JUDG 0, HP 0. Counters 0, key stable = released.
- Reset mid-operation: everything returns to reset values asynchronously. A key still held at reset release is accepted, and pulses, only after DEB_CYCLES cycles of low after synchronisation.

## Timing
- Latency, raw KEY falling edge (held clean) to pulse high:
  - 2 synchroniser cycles, plus DEB_CYCLES counting cycles, plus 1 output register cycle.
  - With DEB_CYCLES=4: pulse in cycle 7 after the first sampled low.
- Pulse width exactly 1 cycle.
- Minimum press-to-press spacing producing two pulses: 2*DEB_CYCLES cycles (press accept plus release accept).
- Switch latency: 2 + DEB_CYCLES cycles, with no output register stage.
- Counter never exceeds DEB_CYCLES-1, so there is no wrap-around.

## Test plan
All scenarios use DEB_CYCLES=4, CNT_W=3.
- Reset check: assert RST=0 mid-run -> all outputs 0, KEY_HELD 0 immediately, with no clock edge needed.
- Clean press: KEY[3] low for 20 cycles, then high.
  - DEC pulses for exactly one cycle, 7 cycles after the first low sample.
  - KEY_HELD[3] stays 1 until 6 cycles after release.
  - No second pulse.
- Bounce: KEY[0] pattern low 2 / high 1 / low 3 / high 1 / low 10 -> exactly one READY pulse, timed from the start of the final low run.
- Simultaneous presses: KEY[1] and KEY[4] fall on the same cycle -> QUE and CLR pulse on the same cycle.
- LOCK: LOCK=1 across a clean KEY[2] press -> no WRONG pulse, but KEY_HELD[2]=1. Release LOCK while the key is still held -> still no pulse.
- Switches: SW from 0 to 7'b1011101 -> SEL=5, JUDG=3, HP=2 after 6 cycles. A 3-cycle SW[0] glitch leaves SEL unchanged.
